// File: rtl/cpu_multicycle.sv
// Multicycle ARM-subset core. Each instruction steps FETCH -> WAIT -> EXEC.
// It executes conditional data-processing and branch instructions.
module cpu_multicycle #(
    parameter int CODE_ADDR_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [CODE_ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]                imem_rdata,
    input  logic                       imem_valid,
    output logic                       retired,
    output logic                       led,
    output logic [7:0]                 debug_port1,
    output logic [7:0]                 debug_port2,
    output logic [7:0]                 debug_port3
);
    typedef enum logic [1:0] {ST_FETCH, ST_WAIT, ST_EXEC} state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       inst_q, inst_d;
    logic [14:0][31:0] rf_q, rf_d;
    logic [3:0]        nzcv_q, nzcv_d;

    logic flag_n, flag_z, flag_c, flag_v;
    assign {flag_n, flag_z, flag_c, flag_v} = nzcv_q;

    logic [3:0]  opc, rn, rd, rm;
    logic        s_bit, is_dp, is_br, writes_rd;
    logic [31:0] pc_plus4, pc_plus8, op_a, op_b, br_off;
    logic        unused_bits;

    assign opc       = inst_q[24:21];
    assign rn        = inst_q[19:16];
    assign rd        = inst_q[15:12];
    assign rm        = inst_q[3:0];
    assign s_bit     = inst_q[20];
    assign is_dp     = (inst_q[27:26] == 2'b00);
    assign is_br     = (inst_q[27:25] == 3'b101);
    assign writes_rd = (opc[3:2] != 2'b10);
    assign pc_plus4  = pc_q + 32'd4;
    assign pc_plus8  = pc_q + 32'd8;
    assign br_off    = {{6{inst_q[23]}}, inst_q[23:0], 2'b00};
    // r15 reads see the pipeline-visible pc+8
    assign op_a      = (rn == 4'd15) ? pc_plus8 : rf_q[rn];
    assign op_b      = inst_q[25] ? {24'd0, inst_q[7:0]}
                                  : ((rm == 4'd15) ? pc_plus8 : rf_q[rm]);
    assign unused_bits = ^inst_q[11:8];

    logic cond_pass;
    always_comb begin
        cond_pass = 1'b0;
        case (inst_q[31:28])
            4'h0: cond_pass = flag_z;
            4'h1: cond_pass = !flag_z;
            4'h2: cond_pass = flag_c;
            4'h3: cond_pass = !flag_c;
            4'h4: cond_pass = flag_n;
            4'h5: cond_pass = !flag_n;
            4'h6: cond_pass = flag_v;
            4'h7: cond_pass = !flag_v;
            4'h8: cond_pass = flag_c && !flag_z;
            4'h9: cond_pass = !flag_c || flag_z;
            4'hA: cond_pass = (flag_n == flag_v);
            4'hB: cond_pass = (flag_n != flag_v);
            4'hC: cond_pass = !flag_z && (flag_n == flag_v);
            4'hD: cond_pass = flag_z || (flag_n != flag_v);
            4'hE: cond_pass = 1'b1;
            4'hF: cond_pass = 1'b0;
        endcase
    end

    // Arithmetic ops share one 33-bit adder; subtracts feed ~operand so C is NOT borrow
    logic [31:0] add_x, add_y, logic_res, alu_res;
    logic        add_cin, arith, alu_v;
    logic [32:0] sum;
    always_comb begin
        add_x     = op_a;
        add_y     = op_b;
        add_cin   = 1'b0;
        arith     = 1'b1;
        logic_res = '0;
        case (opc)
            4'h0, 4'h8: begin arith = 1'b0; logic_res = op_a & op_b; end
            4'h1, 4'h9: begin arith = 1'b0; logic_res = op_a ^ op_b; end
            4'h2, 4'hA: begin add_y = ~op_b; add_cin = 1'b1; end
            4'h3:       begin add_x = op_b; add_y = ~op_a; add_cin = 1'b1; end
            4'h4, 4'hB: begin add_cin = 1'b0; end
            4'h5:       begin add_cin = flag_c; end
            4'h6:       begin add_y = ~op_b; add_cin = flag_c; end
            4'h7:       begin add_x = op_b; add_y = ~op_a; add_cin = flag_c; end
            4'hC:       begin arith = 1'b0; logic_res = op_a | op_b; end
            4'hD:       begin arith = 1'b0; logic_res = op_b; end
            4'hE:       begin arith = 1'b0; logic_res = op_a & ~op_b; end
            default:    begin arith = 1'b0; logic_res = ~op_b; end
        endcase
    end

    assign sum     = {1'b0, add_x} + {1'b0, add_y} + {32'd0, add_cin};
    assign alu_res = arith ? sum[31:0] : logic_res;
    assign alu_v   = (add_x[31] == add_y[31]) && (sum[31] != add_x[31]);

    always_comb begin
        state_d = state_q;
        req_d   = 1'b0;
        pc_d    = pc_q;
        inst_d  = inst_q;
        rf_d    = rf_q;
        nzcv_d  = nzcv_q;
        case (state_q)
            // The first FETCH after reset spends one cycle raising the request
            ST_FETCH: begin
                if (req_q) state_d = ST_WAIT;
                else       req_d   = 1'b1;
            end
            ST_WAIT: begin
                if (imem_valid) begin
                    inst_d  = imem_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                req_d   = 1'b1;
                pc_d    = pc_plus4;
                if (cond_pass && is_dp) begin
                    if (writes_rd && rd == 4'd15) begin
                        pc_d = {alu_res[31:2], 2'b00};
                    end else begin
                        if (writes_rd) rf_d[rd] = alu_res;
                        if (s_bit)
                            nzcv_d = arith ? {alu_res[31], alu_res == 32'd0, sum[32], alu_v}
                                           : {alu_res[31], alu_res == 32'd0, flag_c, flag_v};
                    end
                end else if (cond_pass && is_br) begin
                    pc_d = pc_plus8 + br_off;
                    if (inst_q[24]) rf_d[14] = pc_plus4;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
            req_q   <= 1'b0;
            pc_q    <= '0;
            inst_q  <= '0;
            rf_q    <= '0;
            nzcv_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            rf_q    <= rf_d;
            nzcv_q  <= nzcv_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q[CODE_ADDR_WIDTH+1:2];
    assign retired     = (state_q == ST_EXEC);
    assign led         = pc_q[2];
    assign debug_port1 = pc_q[9:2];
    assign debug_port2 = inst_q[7:0];
    assign debug_port3 = rf_q[2][7:0];
endmodule

// File: doc/cpu_multicycle.md
CPU_MULTICYCLE -- requirements
Module: cpu_multicycle

Interface
REQ-001 SHALL provide parameter CODE_ADDR_WIDTH, default 8, the instruction-memory word-address width (2^CODE_ADDR_WIDTH words).
REQ-002 SHALL provide port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL provide port reset  input  1  asynchronous active-high reset.
REQ-004 SHALL provide port imem_req  output  1  one-cycle fetch request strobe.
REQ-005 SHALL provide port imem_addr  output  CODE_ADDR_WIDTH  word address of the fetch, equal to pc[CODE_ADDR_WIDTH+1:2].
REQ-006 SHALL provide port imem_rdata  input  32  instruction word returned by memory.
REQ-007 SHALL provide port imem_valid  input  1  imem_rdata is valid this cycle.
REQ-008 SHALL provide port retired  output  1  one-cycle pulse per executed or condition-failed instruction.
REQ-009 SHALL provide port led  output  1  equal to pc[2].
REQ-010 SHALL provide ports debug_port1, debug_port2 and debug_port3  output  8 each: pc[9:2], latched inst[7:0] and r2[7:0] respectively.

Function
REQ-011 SHALL sequence through the three states FETCH -> WAIT -> EXEC -> FETCH.
REQ-012 FETCH SHALL assert imem_req for exactly one cycle and then enter WAIT.
REQ-013 WAIT SHALL hold imem_req low and remain in WAIT until imem_valid=1, then latch imem_rdata into inst and enter EXEC; the wait is unbounded, and imem_valid outside WAIT SHALL be ignored.
REQ-014 EXEC SHALL last one cycle, commit all architectural updates at its closing edge, pulse retired, and enter FETCH; minimum latency is 3 cycles per instruction.
REQ-015 Condition (inst[31:28]) SHALL be evaluated against cpsr N/Z/C/V for all ARM codes EQ..AL; code 1111 SHALL never pass.
REQ-016 A failed condition SHALL leave rf and cpsr unchanged and set pc=pc+4.
REQ-017 Data processing (inst[27:26]=00) SHALL use Rn=inst[19:16] and Rd=inst[15:12]; operand2 SHALL be the zero-extended imm8 when inst[25]=1, else rf[inst[3:0]]; there is no shifter.
REQ-018 Register reads of r15 SHALL return pc+8.
REQ-019 All 16 opcodes (AND EOR SUB RSB ADD ADC SBC RSC TST TEQ CMP CMN ORR MOV BIC MVN) SHALL compute with ARM semantics using a 33-bit sum.
REQ-020 For subtract-type opcodes, C SHALL be NOT borrow; for add-type opcodes, C SHALL be the carry out.
REQ-021 V SHALL be signed overflow, (a[31]==b'[31]) && (res[31]!=a[31]), where b' is the effective addend.
REQ-022 Flags SHALL update only when S (inst[20]) is 1; logical opcodes SHALL update N and Z only and leave C and V unchanged.
REQ-023 TST, TEQ, CMP and CMN SHALL never write Rd.
REQ-024 Rd=15 SHALL load pc with {result[31:2],2'b00} and SHALL suppress the flag update.
REQ-025 For Rd≠15, pc SHALL become pc+4.
REQ-026 Branch (inst[27:25]=101) SHALL set pc=pc+8+sign_extend(inst[23:0]<<2).
REQ-027 When the L bit (inst[24]) is 1, the branch SHALL also write r14=pc+4 in the same cycle.
REQ-028 Any other encoding SHALL execute as a NOP: pc+4, retired pulses.
REQ-029 pc arithmetic SHALL wrap modulo 2^32; imem_addr SHALL truncate the upper bits.
REQ-030 At most one register write per instruction SHALL occur.

Reset
REQ-031 reset=1 SHALL immediately force pc=0, r0-r14=0, cpsr=0, inst=0, state=FETCH, imem_req=0 and retired=0, regardless of clk.
REQ-032 Reset asserted in WAIT or EXEC SHALL abandon the instruction with no rf, cpsr or pc commit.
REQ-033 After reset deasserts, the first rising clk edge SHALL enter FETCH activity, with imem_req=1 in the cycle after that edge and imem_addr=0.

Verification
REQ-034 Program MOV r1,#1; ADD r2,r2,r1; B -12 with imem_valid one cycle after imem_req -> debug_port3 reads 1,2,3...; retired pulses every 3 cycles; debug_port1 alternates 1,2.
REQ-035 MVN r4,#0; ADDS r5,r4,#1 -> r5=0, N=0 Z=1 C=1 V=0; a following BEQ is taken and BNE is not.
REQ-036 MOV r6,#0x7F; ADDS r6,r6,r6 (repeated) -> N, V and C match the golden model, including V=1 when 0x7F000000-range sums cross 0x80000000.
REQ-037 BL with imm24=2 at pc=0x10 -> r14=0x14, pc=0x20; MOV r15,r14 then returns to pc=0x14.
REQ-038 imem_valid withheld for 5 cycles in WAIT -> imem_req stays low, no state change and exactly one retired pulse for the instruction.
REQ-039 reset pulsed mid-WAIT and mid-EXEC -> all registers are 0, pc=0 and no write lands; the next imem_addr is 0.
